// File: rtl/uart_tx_fifo.sv
// Host byte buffer feeding uart_top: writes land in count one edge later, launch one edge after that, with a bit-period guard gap per frame.
// Backpressure: full is raised at DEPTH stored bytes; writes while full are dropped and latch the sticky overflow flag.

module uart_tx_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_vld,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow
);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push_vld & ~full;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_vld & full)
                overflow <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; pointer reset alone discards the contents.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_dat;
    end
endmodule

module uart_tx_fifo #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600,
    parameter int DEPTH     = 16,
    parameter int AW        = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    dintx,
    output logic          newd,
    input  logic          donetx,
    output logic          busy
);
    localparam int GAP_LOAD = clk_freq / baud_rate - 1;
    localparam int GW       = (GAP_LOAD < 2) ? 1 : $clog2(GAP_LOAD + 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          donetx_q;
    logic          done_rise;
    logic [GW-1:0] gap_cnt;
    logic          pop;
    logic          gap_load;
    logic          newd_nxt;
    logic [7:0]    pop_dat;

    uart_tx_fifo_buf #(.W(8), .DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk      (clk),
        .rst      (rst),
        .push_vld (wr_en),
        .push_dat (wr_data),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    assign done_rise = donetx & ~donetx_q;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!empty)          state_nxt = SEND;
            SEND:    if (done_rise)       state_nxt = GAP;
            GAP:     if (gap_cnt == '0)   state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop      = (state == IDLE) & ~empty;
        gap_load = (state == SEND) & done_rise;
        newd_nxt = (state_nxt == SEND);
    end

    // dintx only loads at launch, so it is frozen for the whole SEND phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dintx    <= 8'h00;
            newd     <= 1'b0;
            gap_cnt  <= '0;
            donetx_q <= 1'b0;
        end else begin
            donetx_q <= donetx;
            newd     <= newd_nxt;
            if (pop)
                dintx <= pop_dat;
            if (gap_load)
                gap_cnt <= GW'(GAP_LOAD);
            else if (state == GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GW'(1);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a scoreboard of launched bytes and a simple transmitter stand-in.

module tb_uart_tx_fifo;
    localparam int GAP_EXP = 1000000 / 9600 + 1;
    localparam int FRAME   = 20;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow;
    logic [7:0] dintx;
    logic       newd;
    logic       donetx;
    logic       busy;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [7:0] sb[$];
    bit         tx_en = 0;
    int         launches = 0;

    uart_tx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow),
        .dintx    (dintx),
        .newd     (newd),
        .donetx   (donetx),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (!(empty && !busy) && k < budget) begin
            tick();
            k++;
        end
        check(tag, (k < budget), 1);
    endtask

    // Transmitter stand-in: acknowledges each launch after a short frame.
    initial begin
        donetx = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (tx_en && newd === 1'b1) begin
                repeat (FRAME) begin
                    @(posedge clk);
                    #2;
                end
                donetx = 1'b1;
                repeat (2) @(posedge clk);
                #2;
                donetx = 1'b0;
            end
        end
    end

    // Launch monitor: scoreboard pop on newd rise, hold and gap checks.
    bit         prev_newd = 0;
    bit         have_fall = 0;
    bit         gap_exact = 0;
    int         low_cnt   = 0;
    logic [7:0] held      = 8'h00;

    always @(negedge clk) begin
        if (rst === 1'b1 && newd === 1'b1 && !prev_newd) begin
            launches++;
            check("sb_nonempty", (sb.size() != 0), 1);
            if (sb.size() != 0)
                check("launch_byte", dintx, sb.pop_front());
            if (have_fall) begin
                if (gap_exact)
                    check("gap_len", low_cnt, GAP_EXP);
                else
                    check("gap_min", (low_cnt >= GAP_EXP), 1);
            end
            held = dintx;
        end else if (newd === 1'b1 && prev_newd) begin
            check("dintx_stable", dintx, held);
        end else if (newd !== 1'b1 && prev_newd) begin
            have_fall = (rst === 1'b1);
            gap_exact = (count != 0);
            low_cnt   = 1;
        end else begin
            low_cnt++;
        end
        prev_newd = (newd === 1'b1);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int peak;
        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'h00;

        // Reset values
        repeat (5) tick();
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_count", count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_dintx", dintx, 8'h00);
        check("rst_newd", newd, 0);
        check("rst_busy", busy, 0);
        rst   = 1'b1;
        tx_en = 1;
        tick();

        // Single byte
        wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
        tick();
        wr_en = 1'b0;
        check("single_count_after_write", count, 1);
        check("single_empty_after_write", empty, 0);
        check("single_newd_not_yet", newd, 0);
        tick();
        check("single_newd", newd, 1);
        check("single_dintx", dintx, 8'hA5);
        check("single_count_after_launch", count, 0);
        check("single_busy", busy, 1);
        begin
            int k = 0;
            while (donetx !== 1'b1 && k < 200) begin
                tick();
                k++;
            end
            check("single_donetx_seen", (k < 200), 1);
            check("single_release", newd, 0);
        end
        wait_idle("single_idle", 500);

        // Burst 01..05
        base = launches;
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(i); sb.push_back(8'(i));
            tick();
            if (int'(count) > peak) peak = int'(count);
        end
        wr_en = 1'b0;
        check("burst_peak", peak, 4);
        wait_idle("burst_idle", 2000);
        check("burst_launches", launches - base, 5);
        check("burst_sb_drained", sb.size(), 0);
        check("burst_empty", empty, 1);
        check("burst_busy", busy, 0);

        // Full / overflow with transmitter stalled
        tx_en = 0;
        base  = launches;
        for (int i = 0; i < 17; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h10 + i); sb.push_back(8'(8'h10 + i));
            tick();
        end
        wr_en = 1'b0;
        check("full_count", count, 16);
        check("full_flag", full, 1);
        check("full_no_overflow", overflow, 0);
        check("full_newd", newd, 1);
        check("full_dintx", dintx, 8'h10);
        wr_en = 1'b1; wr_data = 8'hEE;
        tick();
        wr_en = 1'b0;
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);
        tx_en = 1;
        wait_idle("full_drain_idle", 5000);
        check("full_launches", launches - base, 17);
        check("full_sb_drained", sb.size(), 0);
        check("ovf_sticky", overflow, 1);

        // Write on the launch edge
        wr_en = 1'b1; wr_data = 8'h77; sb.push_back(8'h77);
        tick();
        wr_data = 8'h3C; sb.push_back(8'h3C);
        tick();
        wr_en = 1'b0;
        check("simul_count", count, 1);
        check("simul_newd", newd, 1);
        check("simul_dintx", dintx, 8'h77);
        wait_idle("simul_idle", 1000);
        check("simul_sb_drained", sb.size(), 0);

        // Reset mid-frame
        tx_en = 0;
        base  = launches;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h41 + i);
            if (i == 0) sb.push_back(8'h41);
            tick();
        end
        wr_en = 1'b0;
        check("midrst_count_before", count, 3);
        check("midrst_newd_before", newd, 1);
        rst = 1'b0;
        tick();
        check("midrst_newd", newd, 0);
        check("midrst_count", count, 0);
        check("midrst_empty", empty, 1);
        check("midrst_busy", busy, 0);
        check("midrst_dintx", dintx, 8'h00);
        check("midrst_overflow", overflow, 0);
        rst   = 1'b1;
        tx_en = 1;
        repeat (300) tick();
        check("midrst_no_stale_newd", newd, 0);
        check("midrst_no_stale_busy", busy, 0);
        check("midrst_launches", launches - base, 1);
        check("midrst_sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and launch controller directly upstream of `uart_top`'s transmit path. It accepts bytes from a host at clock rate into a DEPTH-entry FIFO. It presents them one at a time on `dintx`/`newd`, holding each byte stable until the transmitter reports `donetx`. A one-bit-period guard gap follows each frame before the next byte is launched, so the slow, `uclk`-sampled transmitter never re-sends or misses a byte.

## Interface
- `clk_freq`, 1000000, system clock frequency in Hz (same value given to `uart_top`)
- `baud_rate`, 9600, line rate in baud (same value given to `uart_top`)
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `AW`, 4, log2(DEPTH)

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  synchronous active-low reset; asserted when 0 at a `clk` rising edge
- `wr_en`  in  1  host write strobe, one byte per cycle
- `wr_data`  in  8  host byte
- `full`  out  1  count == DEPTH
- `empty`  out  1  count == 0
- `count`  out  AW+1  bytes stored, excluding the byte currently launched
- `overflow`  out  1  sticky; set by a write while full
- `dintx`  out  8  byte to `uart_top`
- `newd`  out  1  launch request to `uart_top`
- `donetx`  in  1  frame-complete from `uart_top`
- `busy`  out  1  state != IDLE

## Operation
- Storage: `mem[DEPTH]`, `wr_ptr`/`rd_ptr` AW bits, wrap modulo DEPTH; `count` is an explicit register.
- Write: `wr_en & !full` stores `wr_data` at `wr_ptr`, `wr_ptr++`. `wr_en & full` drops the byte and sets `overflow`; pointers and `count` are unchanged.
- `full` is computed from the registered `count`. A write while full is dropped even if a pop occurs in the same cycle.
- FSM states: IDLE, SEND, GAP.
  - IDLE: if `count > 0`, register `dintx <= mem[rd_ptr]`, `rd_ptr++`, `newd <= 1`, go to SEND.
  - SEND: hold `dintx` and `newd=1`. On the rising edge of `donetx` (`donetx & !donetx_q`): `newd <= 0`, load `gap_cnt <= clk_freq/baud_rate - 1`, go to GAP.
  - GAP: `newd=0`, decrement `gap_cnt`; at 0, go to IDLE.
- Count: `count` changes by +1 on an accepted write, -1 on a pop, 0 when both happen in the same cycle.
- Pop occurs only in IDLE, at launch.
- `dintx` holds its last value outside SEND. It is never changed while `newd=1`.
- A `donetx` rising edge seen outside SEND is ignored.
- Reset (rst=0) mid-operation: FSM returns to IDLE, all contents are discarded, and all outputs take their reset values on that edge. Any frame in flight at `uart_top` is not tracked.

## Timing
- Reset values: `full=0`, `empty=1`, `count=0`, `overflow=0`, `dintx=8'h00`, `newd=0`, `busy=0`; pointers 0, `gap_cnt=0`, `donetx_q=0`.
- Write latency: a write at edge N is visible in `count`/`empty` after edge N.
- Launch latency: with the FIFO empty and FSM in IDLE, a write at edge N gives `newd=1` after edge N+1, with `dintx` equal to that byte. `count` returns to 0 after edge N+1.
- Release: a `donetx` rise sampled at edge M gives `newd=0` after edge M+1.
- Gap: minimum spacing from `newd` falling to the next `newd` rising is `clk_freq/baud_rate + 1` clk cycles (105 at defaults).
- Steady state: one byte per frame time plus the gap. No byte is launched twice or skipped.

## Test plan
- Reset: hold rst=0 for 5 cycles -> every output equals its reset value; `empty=1`.
- Single byte: write 8'hA5 into an empty FIFO -> `newd=1`, `dintx=8'hA5` two edges after the write. `tx` frame carries A5 LSB-first. `newd` falls one edge after `donetx`, then stays low for ≥105 cycles.
- Burst: write 8'h01..8'h05 on consecutive cycles -> `count` peaks at 4. Five frames carry 01,02,03,04,05 in order, each exactly once. Ends with `empty=1`, `busy=0`.
- Full/overflow at DEPTH=16: write 17 bytes with the transmitter stalled (`donetx` held 0) -> the first byte is launched, 16 are stored, `full=1`. The 18th write sets `overflow=1` and the stored data is unchanged.
- Simultaneous write and pop: with count=1 in IDLE, write 8'h3C on the launch edge -> `count` stays 1; 8'h3C is sent next.
- Reset mid-frame: assert rst=0 during SEND with 3 bytes queued -> `newd=0`, `count=0` next edge. After release, no stale byte is launched.
